alu_datapath: RTL and testbench
===============================

Name: alu_datapath

Overview:
Execution datapath driven by the microprogram sequencer's 17-bit control word. Each cycle it decodes the word and reads two operands from a 4-entry register file, an immediate, or the external input port. It computes an ALU result and conditionally writes back the result, the Carry/Zero flags and the output register. The registered Carry/Zero flags feed the sequencer's conditional-jump logic. The all-zero word that the sequencer emits during jump cycles is a strict NOP.

Parameters:
DATA_W, 8, datapath/register width in bits; legal values are 4 or more.
OUT_RST, 0, reset value of data_out, DATA_W bits.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
ControlBus  input  17  microinstruction control word.
data_in  input  DATA_W  external input operand.
CarryFlag  output  1  registered carry flag.
ZeroFlag  output  1  registered zero flag.
data_out  output  DATA_W  registered output port.

Behaviour:
- Control word fields:
  - [16:14] op
  - [13:12] dst
  - [11:10] srcA
  - [9:8] srcB
  - [7] reg_we
  - [6] flag_we
  - [5] out_we
  - [4] imm_sel
  - [3:0] imm4
- Operands:
  - A = R[srcA].
  - B = imm_sel ? zero-extended imm4 : R[srcB]. When DATA_W=4, imm4 is used as-is.
- op encoding:
  - 000 ADD: res = A+B; C = carry-out of bit DATA_W-1.
  - 001 SUB: res = A-B; C = 1 when A>=B unsigned (no borrow). With this rule, !Z&C means A>B and Z&C means A==B.
  - 010 AND, 011 OR, 100 XOR: C = 0.
  - 101 SHL: res = A<<1; C = A[DATA_W-1].
  - 110 SHR (logical): res = A>>1; C = A[0].
  - 111 IN: res = data_in; C = 0.
- Z = (res == 0), computed on the DATA_W-bit truncated result.
- Result and flags are combinational within the cycle. State updates at the clock edge:
  - reg_we=1: R[dst] <= res.
  - flag_we=1: CarryFlag <= C and ZeroFlag <= Z, both together.
  - out_we=1: data_out <= res.
  - Write enables are independent; any combination is legal.
- Latency: a write becomes visible to reads, flags and ports one cycle after the issuing word.
- No bypass. If srcA or srcB equals dst of the same word, the read returns the pre-edge value (e.g. R0 <= R0+1 is legal).
- ControlBus = 0 (or any word with reg_we=flag_we=out_we=0) changes no state. Flags hold their value across NOP and jump cycles.
- Reset (asynchronous assert, release on the next edge after deassert):
  - R0..R3 = 0
  - CarryFlag = 0
  - ZeroFlag = 0
  - data_out = OUT_RST
- Reset asserted mid-sequence clears all state immediately, regardless of ControlBus.
- Arithmetic wraps modulo 2^DATA_W and no overflow flag exists. Example: 0xFF+0x01 gives res 0x00, C=1, Z=1.

Optional Feature:
ALU_DP_DBG_EN:
- When defined, adds input dbg_sel (2 bits) and output dbg_data (DATA_W bits). dbg_data = R[dbg_sel] combinationally, showing the pre-edge register value, for display on board LEDs.
- The debug read port has no side effects and does not alter ALU or flag behaviour.
- When undefined, neither port exists and no extra logic is generated.

Decomposition:
- Package alu_dp_pkg holds:
  - op constants OP_ADD..OP_IN
  - control-word field bit positions/widths (OP_MSB/LSB, DST_LSB, SRCA_LSB, SRCB_LSB, REG_WE_BIT, FLAG_WE_BIT, OUT_WE_BIT, IMM_SEL_BIT, IMM_LSB/W)
  - CW_W = 17
- One combinational sub-module, alu_dp_alu:
  - inputs: op, A, B, data_in
  - outputs: res, C, Z
- The top level owns the register file, flag registers, output register and field decode.

Test Plan:
- Reset: drive reset=0 with random ControlBus and data_in -> all registers, flags and data_out equal 0/OUT_RST, and they hold through reset release.
- Immediate load/add: R0 <= 0 OR imm 5, then R1 <= R0 ADD imm 9 with flag_we -> R1=14, C=0, Z=0. Verify via the out_we copy, data_out=0x0E.
- Wrap: R2=0xFF, then R2 ADD imm 1 with flag_we, reg_we -> R2=0x00, C=1, Z=1.
- Compare: R0=7, R1=7, SUB with flag_we only -> Z=1, C=1, registers unchanged. With R1=9 -> Z=0, C=0.
- NOP/jump cycles: after flags C=1, Z=0, drive ControlBus=0 for 5 cycles -> flags, registers and data_out unchanged.
- Shifts/IN and same-register read/write: data_in=0x81, IN to R3, then R3 SHL with flag_we -> R3=0x02, C=1. Then R3 SHR -> R3=0x01, C=0. R0 <= R0 ADD imm 1 repeated 3 times from 0 -> R0=3.

Source files
------------

// File: rtl/alu_dp_pkg.sv
// alu_dp_pkg: shared definitions for the alu_datapath block.
//   - ALU op encodings (OP_ADD..OP_IN)
//   - control-word field positions and widths
//   - CW_W: control word width (17)
package alu_dp_pkg;

    localparam int unsigned CW_W = 17;

    // Control word field layout
    localparam int unsigned OP_W        = 3;
    localparam int unsigned OP_MSB      = 16;
    localparam int unsigned OP_LSB      = 14;
    localparam int unsigned SEL_W       = 2;
    localparam int unsigned DST_LSB     = 12;
    localparam int unsigned SRCA_LSB    = 10;
    localparam int unsigned SRCB_LSB    = 8;
    localparam int unsigned REG_WE_BIT  = 7;
    localparam int unsigned FLAG_WE_BIT = 6;
    localparam int unsigned OUT_WE_BIT  = 5;
    localparam int unsigned IMM_SEL_BIT = 4;
    localparam int unsigned IMM_LSB     = 0;
    localparam int unsigned IMM_W       = 4;

    // ALU operations
    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_SHL = 3'b101;
    localparam logic [OP_W-1:0] OP_SHR = 3'b110;
    localparam logic [OP_W-1:0] OP_IN  = 3'b111;

endpackage

// File: rtl/alu_dp_alu.sv
// alu_dp_alu: purely combinational ALU for alu_datapath.
// Ports:
//   op      - operation select (OP_* from alu_dp_pkg)
//   a, b    - operands
//   data_in - external input, passed through by OP_IN
//   res     - DATA_W-bit result (wraps modulo 2^DATA_W)
//   c       - carry: ADD carry-out, SUB no-borrow (a >= b), shifted-out bit for shifts, else 0
//   z       - result equals zero
module alu_dp_alu
    import alu_dp_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] res,
    output logic              c,
    output logic              z
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // One extra bit captures carry-out / borrow
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        res = '0;
        c   = 1'b0;
        case (op)
            OP_ADD: begin
                res = sum[DATA_W-1:0];
                c   = sum[DATA_W];
            end
            OP_SUB: begin
                res = diff[DATA_W-1:0];
                c   = ~diff[DATA_W];  // no borrow means a >= b
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: begin
                res = {a[DATA_W-2:0], 1'b0};
                c   = a[DATA_W-1];
            end
            OP_SHR: begin
                res = {1'b0, a[DATA_W-1:1]};
                c   = a[0];
            end
            OP_IN:  res = data_in;
            default: begin
                res = '0;
                c   = 1'b0;
            end
        endcase
    end

    assign z = (res == '0);

endmodule

// File: rtl/alu_datapath.sv
// alu_datapath: execution datapath driven by a 17-bit microinstruction word.
// Decodes the word, reads operands from a 4-entry register file (or imm4 / data_in),
// and conditionally writes back register, Carry/Zero flags and the output register.
// An all-zero control word is a strict NOP.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   ControlBus - control word {op, dst, srcA, srcB, reg_we, flag_we, out_we, imm_sel, imm4}
//   data_in    - external operand used by OP_IN
//   CarryFlag  - registered carry flag
//   ZeroFlag   - registered zero flag
//   data_out   - registered output port, resets to OUT_RST
// Optional: define ALU_DP_DBG_EN to add dbg_sel (in, 2b) and dbg_data (out, DATA_W),
//   a side-effect-free combinational read of R[dbg_sel].
module alu_datapath
    import alu_dp_pkg::*;
#(
    parameter int unsigned       DATA_W  = 8,
    parameter logic [DATA_W-1:0] OUT_RST = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CW_W-1:0]   ControlBus,
    input  logic [DATA_W-1:0] data_in,
`ifdef ALU_DP_DBG_EN
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
`endif
    output logic              CarryFlag,
    output logic              ZeroFlag,
    output logic [DATA_W-1:0] data_out
);

    // Field decode
    logic [OP_W-1:0]  op;
    logic [SEL_W-1:0] dst;
    logic [SEL_W-1:0] src_a;
    logic [SEL_W-1:0] src_b;
    logic             reg_we;
    logic             flag_we;
    logic             out_we;
    logic             imm_sel;
    logic [IMM_W-1:0] imm4;

    assign op      = ControlBus[OP_MSB:OP_LSB];
    assign dst     = ControlBus[DST_LSB +: SEL_W];
    assign src_a   = ControlBus[SRCA_LSB +: SEL_W];
    assign src_b   = ControlBus[SRCB_LSB +: SEL_W];
    assign reg_we  = ControlBus[REG_WE_BIT];
    assign flag_we = ControlBus[FLAG_WE_BIT];
    assign out_we  = ControlBus[OUT_WE_BIT];
    assign imm_sel = ControlBus[IMM_SEL_BIT];
    assign imm4    = ControlBus[IMM_LSB +: IMM_W];

    // State
    logic [DATA_W-1:0] regs_q [4];
    logic              carry_q;
    logic              zero_q;
    logic [DATA_W-1:0] out_q;

    // Operand selection; reads always see pre-edge register values (no bypass)
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    always_comb begin
        imm_ext          = '0;
        imm_ext[3:0]     = imm4;
    end

    assign opnd_a = regs_q[src_a];
    assign opnd_b = imm_sel ? imm_ext : regs_q[src_b];

    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_z;

    alu_dp_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op      (op),
        .a       (opnd_a),
        .b       (opnd_b),
        .data_in (data_in),
        .res     (alu_res),
        .c       (alu_c),
        .z       (alu_z)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            out_q   <= OUT_RST;
        end else begin
            if (reg_we) begin
                regs_q[dst] <= alu_res;
            end
            if (flag_we) begin
                carry_q <= alu_c;
                zero_q  <= alu_z;
            end
            if (out_we) begin
                out_q <= alu_res;
            end
        end
    end

    assign CarryFlag = carry_q;
    assign ZeroFlag  = zero_q;
    assign data_out  = out_q;

`ifdef ALU_DP_DBG_EN
    assign dbg_data = regs_q[dbg_sel];
`endif

endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath: directed self-checking bench for alu_datapath (DATA_W=8, OUT_RST=8'h5A).
// Register contents are observed by issuing an OR-with-imm-0 word that copies R[x] to data_out.
module tb_alu_datapath;

    localparam int unsigned    DW     = 8;
    localparam logic [DW-1:0]  OUTRST = 8'h5A;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] SHL = 3'b101;
    localparam logic [2:0] SHR = 3'b110;
    localparam logic [2:0] IN  = 3'b111;

    logic          clk;
    logic          reset;
    logic [16:0]   cbus;
    logic [DW-1:0] din;
    logic          cflag;
    logic          zflag;
    logic [DW-1:0] dout;

    int n_cmp = 0;
    int n_err = 0;

    alu_datapath #(
        .DATA_W  (DW),
        .OUT_RST (OUTRST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ControlBus (cbus),
        .data_in    (din),
        .CarryFlag  (cflag),
        .ZeroFlag   (zflag),
        .data_out   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] cw(input logic [2:0] op, input logic [1:0] dst,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic rw, input logic fw, input logic ow,
                                       input logic is, input logic [3:0] imm);
        return {op, dst, sa, sb, rw, fw, ow, is, imm};
    endfunction

    // Apply one word for one clock; outputs are sampled 1 time unit after the edge
    task automatic issue(input logic [16:0] w);
        cbus = w;
        @(posedge clk);
        #1;
        cbus = '0;
    endtask

    // Copy R[r] to data_out without touching registers or flags
    task automatic peek(input logic [1:0] r);
        issue(cw(OR, 2'd0, r, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0));
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cbus  = 17'($urandom);
        din   = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (dout !== OUTRST) begin n_err++;
            $display("FAIL reset_dout: got %h expected %h", dout, OUTRST); end
        n_cmp++; if ({cflag, zflag} !== 2'b00) begin n_err++;
            $display("FAIL reset_flags: got %b expected 00", {cflag, zflag}); end
        cbus  = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (dout !== OUTRST || {cflag, zflag} !== 2'b00) begin n_err++;
            $display("FAIL reset_release: got %h/%b expected %h/00", dout, {cflag, zflag},
                     OUTRST); end
        for (int r = 0; r < 4; r++) begin
            peek(2'(r));
            n_cmp++; if (dout !== 8'h00) begin n_err++;
                $display("FAIL reset_reg%0d: got %h expected 00", r, dout); end
        end
    endtask

    task automatic test_imm_add();
        issue(cw(OR, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5));
        issue(cw(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd9));
        n_cmp++; if (dout !== 8'h0E) begin n_err++;
            $display("FAIL imm_add_out: got %h expected 0e", dout); end
        n_cmp++; if ({cflag, zflag} !== 2'b00) begin n_err++;
            $display("FAIL imm_add_flags: got %b expected 00", {cflag, zflag}); end
        peek(2'd1);
        n_cmp++; if (dout !== 8'h0E) begin n_err++;
            $display("FAIL imm_add_r1: got %h expected 0e", dout); end
    endtask

    task automatic test_wrap();
        din = 8'hFF;
        issue(cw(IN, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
        issue(cw(ADD, 2'd2, 2'd2, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1));
        n_cmp++; if ({cflag, zflag} !== 2'b11) begin n_err++;
            $display("FAIL wrap_flags: got %b expected 11", {cflag, zflag}); end
        peek(2'd2);
        n_cmp++; if (dout !== 8'h00) begin n_err++;
            $display("FAIL wrap_r2: got %h expected 00", dout); end
        n_cmp++; if ({cflag, zflag} !== 2'b11) begin n_err++;
            $display("FAIL wrap_flags_hold: got %b expected 11", {cflag, zflag}); end
    endtask

    task automatic test_compare();
        din = 8'h07;
        issue(cw(IN, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
        issue(cw(IN, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
        din = 8'h00;
        issue(cw(SUB, 2'd0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0));
        n_cmp++; if ({cflag, zflag} !== 2'b11) begin n_err++;
            $display("FAIL cmp_eq_flags: got %b expected 11", {cflag, zflag}); end
        peek(2'd0);
        n_cmp++; if (dout !== 8'h07) begin n_err++;
            $display("FAIL cmp_eq_r0: got %h expected 07", dout); end
        din = 8'h09;
        issue(cw(IN, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
        issue(cw(SUB, 2'd0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0));
        n_cmp++; if ({cflag, zflag} !== 2'b00) begin n_err++;
            $display("FAIL cmp_lt_flags: got %b expected 00", {cflag, zflag}); end
        // 9 - 7 = 2, A > B
        issue(cw(SUB, 2'd0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0));
        n_cmp++; if ({cflag, zflag, dout} !== {2'b10, 8'h02}) begin n_err++;
            $display("FAIL cmp_gt: got %b/%h expected 10/02", {cflag, zflag}, dout); end
    endtask

    task automatic test_nop();
        for (int i = 0; i < 5; i++) begin
            din = 8'($urandom);
            issue(17'd0);
            n_cmp++; if ({cflag, zflag, dout} !== {2'b10, 8'h02}) begin n_err++;
                $display("FAIL nop_hold%0d: got %b/%h expected 10/02", i, {cflag, zflag}, dout);
            end
        end
        peek(2'd1);
        n_cmp++; if (dout !== 8'h09) begin n_err++;
            $display("FAIL nop_r1: got %h expected 09", dout); end
    endtask

    task automatic test_logic();
        // R0 = 07, R1 = 09
        issue(cw(AND, 2'd0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0));
        n_cmp++; if ({cflag, zflag, dout} !== {2'b00, 8'h01}) begin n_err++;
            $display("FAIL and: got %b/%h expected 00/01", {cflag, zflag}, dout); end
        issue(cw(XOR, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
        n_cmp++; if (dout !== 8'h0E) begin n_err++;
            $display("FAIL xor: got %h expected 0e", dout); end
        issue(cw(OR, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
        n_cmp++; if (dout !== 8'h0F) begin n_err++;
            $display("FAIL or: got %h expected 0f", dout); end
        issue(cw(XOR, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0));
        n_cmp++; if ({cflag, zflag} !== 2'b01) begin n_err++;
            $display("FAIL xor_zero: got %b expected 01", {cflag, zflag}); end
    endtask

    task automatic test_shift();
        din = 8'h81;
        issue(cw(IN, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
        din = 8'h00;
        issue(cw(SHL, 2'd3, 2'd3, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0));
        n_cmp++; if ({cflag, zflag, dout} !== {2'b10, 8'h02}) begin n_err++;
            $display("FAIL shl: got %b/%h expected 10/02", {cflag, zflag}, dout); end
        issue(cw(SHR, 2'd3, 2'd3, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0));
        n_cmp++; if ({cflag, zflag, dout} !== {2'b00, 8'h01}) begin n_err++;
            $display("FAIL shr: got %b/%h expected 00/01", {cflag, zflag}, dout); end
        issue(cw(SHR, 2'd3, 2'd3, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0));
        n_cmp++; if ({cflag, zflag, dout} !== {2'b11, 8'h00}) begin n_err++;
            $display("FAIL shr_out: got %b/%h expected 11/00", {cflag, zflag}, dout); end
    endtask

    task automatic test_same_reg();
        din = 8'h00;
        issue(cw(IN, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
        for (int i = 1; i <= 3; i++) begin
            issue(cw(ADD, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1));
            n_cmp++; if (dout !== 8'(i)) begin n_err++;
                $display("FAIL inc%0d: got %h expected %h", i, dout, 8'(i)); end
        end
        peek(2'd0);
        n_cmp++; if (dout !== 8'h03) begin n_err++;
            $display("FAIL inc_r0: got %h expected 03", dout); end
    endtask

    task automatic test_back_to_back();
        // Establish non-reset state, then assert reset between clock edges
        issue(cw(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF));
        n_cmp++; if ({cflag, zflag, dout} !== {2'b00, 8'h12}) begin n_err++;
            $display("FAIL pre_rst: got %b/%h expected 00/12", {cflag, zflag}, dout); end
        cbus = cw(SUB, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if ({cflag, zflag, dout} !== {2'b00, OUTRST}) begin n_err++;
            $display("FAIL async_rst: got %b/%h expected 00/%h", {cflag, zflag}, dout, OUTRST);
        end
        @(posedge clk);
        #1;
        cbus  = '0;
        reset = 1'b1;
        peek(2'd0);
        n_cmp++; if (dout !== 8'h00) begin n_err++;
            $display("FAIL async_rst_r0: got %h expected 00", dout); end
        peek(2'd1);
        n_cmp++; if (dout !== 8'h00) begin n_err++;
            $display("FAIL async_rst_r1: got %h expected 00", dout); end
    endtask

    initial begin
        reset = 1'b0;
        cbus  = '0;
        din   = '0;
        test_reset();
        test_imm_add();
        test_wrap();
        test_compare();
        test_nop();
        test_logic();
        test_shift();
        test_same_reg();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
